l1_miss_queue: RTL and testbench

- Sits directly downstream of the L1 data cache.
- Buffers the miss, write-through and line-flush (CLF) requests that L1 forwards, issues them in order to the lower cache (L2) one at a time, and routes the 128-bit fill returned by L2 back to L1.
- Decouples L1 from L2 latency so that L1 can post several misses before it stalls.

---
 rtl/l1_miss_queue.sv | 146 ++++++++++++++
 tb/tb_l1_miss_queue.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_miss_queue.sv
// In-order miss/write-through/CLF queue between L1 and L2; one L2 request outstanding at a time.
// Optional per-type L2 request counters when L1_MISS_QUEUE_STATS_EN is defined.
module l1_miss_queue #(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 64,
  parameter int LINE_OFF = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_we,
  input  logic                       in_clf,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [63:0]                in_wdata,
  input  logic [2:0]                 in_size,
  output logic                       l2_req_valid,
  input  logic                       l2_req_ready,
  output logic                       l2_we,
  output logic                       l2_clf,
  output logic [ADDR_W-1:0]          l2_addr,
  output logic [63:0]                l2_wdata,
  output logic [2:0]                 l2_size,
  input  logic                       l2_fill_valid,
  input  logic [127:0]               l2_fill_data,
  output logic                       fill_valid,
  input  logic                       fill_ready,
  output logic [ADDR_W-1:0]          fill_addr,
  output logic [127:0]               fill_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err_unexp_fill
`ifdef L1_MISS_QUEUE_STATS_EN
  ,
  output logic [31:0]                stat_reads,
  output logic [31:0]                stat_writes,
  output logic [31:0]                stat_clfs
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << LINE_OFF) - ADDR_W'(1));

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_FILL, S_RETURN} state_t;

  state_t            state;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] q_addr  [DEPTH];
  logic [63:0]       q_wdata [DEPTH];
  logic [2:0]        q_size  [DEPTH];
  logic              q_we    [DEPTH];
  logic              q_clf   [DEPTH];
  logic              push, pop;

  assign in_ready = (count != FULL);
  assign push     = in_valid && in_ready;
  // l2_we/l2_clf mirror the head entry while in ISSUE, so they decide the pop
  assign pop = ((state == S_ISSUE) && l2_req_ready && (l2_we || l2_clf)) ||
               ((state == S_RETURN) && fill_ready);

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr]  <= (in_clf || !in_we) ? (in_addr & LINE_MASK) : in_addr;
      q_wdata[wr_ptr] <= in_wdata;
      q_size[wr_ptr]  <= (in_size > 3'd3) ? 3'd3 : in_size;
      q_we[wr_ptr]    <= in_we && !in_clf;
      q_clf[wr_ptr]   <= in_clf;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      l2_req_valid   <= 1'b0;
      l2_we          <= 1'b0;
      l2_clf         <= 1'b0;
      l2_addr        <= '0;
      l2_wdata       <= '0;
      l2_size        <= '0;
      fill_valid     <= 1'b0;
      fill_addr      <= '0;
      fill_data      <= '0;
      err_unexp_fill <= 1'b0;
`ifdef L1_MISS_QUEUE_STATS_EN
      stat_reads     <= '0;
      stat_writes    <= '0;
      stat_clfs      <= '0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);

      if (l2_fill_valid && (state != S_WAIT_FILL)) err_unexp_fill <= 1'b1;

      case (state)
        S_IDLE: begin
          if (count != '0) begin
            state        <= S_ISSUE;
            l2_req_valid <= 1'b1;
            l2_addr      <= q_addr[rd_ptr];
            l2_wdata     <= q_wdata[rd_ptr];
            l2_size      <= q_size[rd_ptr];
            l2_we        <= q_we[rd_ptr];
            l2_clf       <= q_clf[rd_ptr];
          end
        end
        S_ISSUE: begin
          if (l2_req_ready) begin
            l2_req_valid <= 1'b0;
            state        <= (l2_we || l2_clf) ? S_IDLE : S_WAIT_FILL;
`ifdef L1_MISS_QUEUE_STATS_EN
            if (l2_clf) begin
              if (stat_clfs != '1) stat_clfs <= stat_clfs + 32'd1;
            end else if (l2_we) begin
              if (stat_writes != '1) stat_writes <= stat_writes + 32'd1;
            end else begin
              if (stat_reads != '1) stat_reads <= stat_reads + 32'd1;
            end
`endif
          end
        end
        S_WAIT_FILL: begin
          if (l2_fill_valid) begin
            fill_data  <= l2_fill_data;
            fill_addr  <= q_addr[rd_ptr];
            fill_valid <= 1'b1;
            state      <= S_RETURN;
          end
        end
        S_RETURN: begin
          if (fill_ready) begin
            fill_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_miss_queue.sv
// Bench for l1_miss_queue: directed scenarios plus random traffic checked against a queue-based model.
module tb_l1_miss_queue;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, in_we, in_clf;
  logic [63:0]  in_addr, in_wdata;
  logic [2:0]   in_size;
  logic         l2_req_valid, l2_req_ready, l2_we, l2_clf;
  logic [63:0]  l2_addr, l2_wdata;
  logic [2:0]   l2_size;
  logic         l2_fill_valid;
  logic [127:0] l2_fill_data;
  logic         fill_valid, fill_ready;
  logic [63:0]  fill_addr;
  logic [127:0] fill_data;
  logic [2:0]   count;
  logic         err_unexp_fill;
`ifdef L1_MISS_QUEUE_STATS_EN
  logic [31:0]  stat_reads, stat_writes, stat_clfs;
  int           m_reads, m_writes, m_clfs;
`endif

  l1_miss_queue #(.DEPTH(DEPTH), .ADDR_W(64), .LINE_OFF(6)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_clf(in_clf),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_size(in_size),
    .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready), .l2_we(l2_we), .l2_clf(l2_clf),
    .l2_addr(l2_addr), .l2_wdata(l2_wdata), .l2_size(l2_size),
    .l2_fill_valid(l2_fill_valid), .l2_fill_data(l2_fill_data),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr), .fill_data(fill_data),
    .count(count), .err_unexp_fill(err_unexp_fill)
`ifdef L1_MISS_QUEUE_STATS_EN
    , .stat_reads(stat_reads), .stat_writes(stat_writes), .stat_clfs(stat_clfs)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic        clf;
    logic [63:0] wdata;
    logic [2:0]  size;
  } req_t;

  // Model: pending requests in order, plus which phase the head is in
  // (0 waiting to issue, 1 presented to L2, 2 awaiting fill, 3 fill offered to L1).
  req_t         q[$];
  int           ph;
  bit           m_err;
  logic [63:0]  m_fill_addr;
  logic [127:0] m_fill_data;
  int           vectors = 0;
  int           miscompares = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ph = 0;
    m_err = 1'b0;
`ifdef L1_MISS_QUEUE_STATS_EN
    m_reads = 0; m_writes = 0; m_clfs = 0;
`endif
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_we = 1'b0; in_clf = 1'b0; in_addr = '0; in_wdata = '0; in_size = '0;
    l2_req_ready = 1'b0; l2_fill_valid = 1'b0; l2_fill_data = '0; fill_ready = 1'b0;
  endtask

  // Called at a negedge with inputs already driven: check outputs, advance model, move to next negedge.
  task automatic step();
    req_t r;
    bit   push_ok;
    chk("in_ready", in_ready, q.size() != DEPTH);
    chk("count", count, q.size());
    chk("l2_req_valid", l2_req_valid, ph == 1);
    chk("fill_valid", fill_valid, ph == 3);
    chk("err_unexp_fill", err_unexp_fill, m_err);
    if (ph == 1) begin
      chk("l2_addr", l2_addr, q[0].addr);
      chk("l2_we", l2_we, q[0].we);
      chk("l2_clf", l2_clf, q[0].clf);
      chk("l2_wdata", l2_wdata, q[0].wdata);
      chk("l2_size", l2_size, q[0].size);
    end
    if (ph == 3) begin
      chk("fill_addr", fill_addr, m_fill_addr);
      chk("fill_data", fill_data, m_fill_data);
    end
`ifdef L1_MISS_QUEUE_STATS_EN
    chk("stat_reads", stat_reads, m_reads);
    chk("stat_writes", stat_writes, m_writes);
    chk("stat_clfs", stat_clfs, m_clfs);
`endif
    push_ok = in_valid && (q.size() != DEPTH);
    if (l2_fill_valid && ph != 2) m_err = 1'b1;
    case (ph)
      0: if (q.size() != 0) ph = 1;
      1: if (l2_req_ready) begin
`ifdef L1_MISS_QUEUE_STATS_EN
           if (q[0].clf) m_clfs++; else if (q[0].we) m_writes++; else m_reads++;
`endif
           if (q[0].we || q[0].clf) begin q.delete(0); ph = 0; end
           else ph = 2;
         end
      2: if (l2_fill_valid) begin
           m_fill_addr = q[0].addr; m_fill_data = l2_fill_data; ph = 3;
         end
      default: if (fill_ready) begin q.delete(0); ph = 0; end
    endcase
    if (push_ok) begin
      r.clf   = in_clf;
      r.we    = in_clf ? 1'b0 : in_we;
      r.addr  = (in_clf || !in_we) ? {in_addr[63:6], 6'b0} : in_addr;
      r.wdata = in_wdata;
      r.size  = (in_size > 3'd3) ? 3'd3 : in_size;
      q.push_back(r);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || ph != 0) && n < 200) begin
      in_valid = 1'b0; l2_req_ready = 1'b1; fill_ready = 1'b1;
      l2_fill_valid = (ph == 2);
      l2_fill_data = {$urandom, $urandom, $urandom, $urandom};
      step();
      n++;
    end
    chk("drain_timeout", n < 200, 1'b1);
    idle_inputs();
  endtask

  task automatic push_one(input logic we, input logic clf, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [2:0] size);
    in_valid = 1'b1; in_we = we; in_clf = clf; in_addr = addr; in_wdata = wdata; in_size = size;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_issue();
    int n = 0;
    while (!l2_req_valid && n < 20) begin step(); n++; end
    chk("issue_timeout", l2_req_valid, 1'b1);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_count", count, 0);
    chk("rst_l2_req_valid", l2_req_valid, 1'b0);
    reset = 1'b0;
    in_valid = 1'b0;

    // Line alignment of a read miss; exact two-edge latency is checked by the model
    push_one(1'b0, 1'b0, 64'h1234_5678, 64'h0, 3'd0);
    step();
    chk("align_l2_addr", l2_addr, 64'h1234_5640);
    chk("align_l2_we", l2_we, 1'b0);
    drain();

    // Read miss with a delayed fill
    push_one(1'b0, 1'b0, 64'h80, 64'h0, 3'd0);
    l2_req_ready = 1'b1;
    wait_issue();
    step();
    l2_req_ready = 1'b0;
    repeat (2) step();
    l2_fill_valid = 1'b1; l2_fill_data = {16{8'hA5}};
    step();
    l2_fill_valid = 1'b0;
    chk("rd_fill_valid", fill_valid, 1'b1);
    chk("rd_fill_addr", fill_addr, 64'h80);
    chk("rd_fill_data", fill_data, {16{8'hA5}});
    fill_ready = 1'b1;
    step();
    fill_ready = 1'b0;
    chk("rd_count_after_pop", count, 0);

    // Fill the queue with writes while L2 stalls, then pop while a push is attempted
    for (int i = 0; i < DEPTH; i++)
      push_one(1'b1, 1'b0, 64'h1000 + 64'(i * 9), 64'hDEAD_0000 + 64'(i), 3'(i + 2));
    chk("full_count", count, DEPTH);
    chk("full_in_ready", in_ready, 1'b0);
    in_valid = 1'b1; in_we = 1'b1; in_addr = 64'hBAD; in_wdata = 64'hBAD; in_size = 3'd1;
    l2_req_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("full_pop_count", count, DEPTH - 1);
    drain();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid      = ($urandom_range(0, 1) == 1);
      in_clf        = ($urandom_range(0, 3) == 0);
      in_we         = ($urandom_range(0, 1) == 1);
      in_addr       = {$urandom, $urandom};
      in_wdata      = {$urandom, $urandom};
      in_size       = 3'($urandom_range(0, 7));
      l2_req_ready  = ($urandom_range(0, 2) != 0);
      l2_fill_valid = (ph == 2) && ($urandom_range(0, 2) == 0);
      l2_fill_data  = {$urandom, $urandom, $urandom, $urandom};
      fill_ready    = ($urandom_range(0, 1) == 1);
      step();
    end
    drain();

    // Asynchronous reset while a read waits for its fill
    push_one(1'b0, 1'b0, 64'h3333_0000, 64'h0, 3'd0);
    l2_req_ready = 1'b1;
    wait_issue();
    step();
    l2_req_ready = 1'b0;
    chk("pre_rst_wait_fill", ph == 2 && !l2_req_valid && !fill_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_count", count, 0);
    chk("arst_l2_req_valid", l2_req_valid, 1'b0);
    chk("arst_fill_valid", fill_valid, 1'b0);
    chk("arst_err", err_unexp_fill, 1'b0);
    chk("arst_l2_bus", {l2_addr, l2_wdata, l2_size, l2_we, l2_clf}, '0);
    chk("arst_fill_addr", fill_addr, 0);
    chk("arst_fill_data", fill_data, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    push_one(1'b1, 1'b1, 64'h7F, 64'h55, 3'd3);
    wait_issue();
    chk("clf_l2_clf", l2_clf, 1'b1);
    chk("clf_l2_we", l2_we, 1'b0);
    chk("clf_l2_addr", l2_addr, 64'h40);
    l2_req_ready = 1'b1;
    step();
    l2_req_ready = 1'b0;
`ifdef L1_MISS_QUEUE_STATS_EN
    chk("clf_stat_clfs", stat_clfs, 1);
`endif
    drain();

    // Fill arriving while idle is flagged and discarded
    l2_fill_valid = 1'b1; l2_fill_data = {4{32'hFEED_F00D}};
    step();
    l2_fill_valid = 1'b0;
    repeat (3) step();
    chk("unexp_err", err_unexp_fill, 1'b1);
    chk("unexp_fill_valid", fill_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
